// File: rtl/hex_scroll_display.sv
`default_nettype none
// ============================================================================
//  Module      : hex_scroll_display
//  Description : Watches the 4-bit digit stream of the hex Moore sequencer,
//                captures every change into a scrolling DIGITS-deep history,
//                drives a multiplexed seven-segment display from it, and
//                checks that the stream cycles C,0,E,3,1,2 in order.
//  Ports       : clk       - system clock, rising edge
//                reset     - synchronous, active-high reset
//                digit_in  - hex digit from the sequencer (no strobe)
//                seg       - registered segment drive {g,f,e,d,c,b,a}
//                an        - registered one-hot position enable
//                new_digit - one-cycle pulse per captured digit
//                seq_err   - one-cycle pulse on an out-of-order digit
//                seq_lock  - high once a full C,0,E,3,1,2 cycle is seen
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_scroll_display #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        digit_in,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              new_digit,
    output logic              seq_err,
    output logic              seq_lock
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [6:0]        c_seg_blank = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] c_an_pos0   = DIGITS'(1);
    localparam logic [DIGITS-1:0] c_an_rst    = SEG_ACTIVE_LOW ? ~c_an_pos0 : c_an_pos0;

    typedef enum logic [0:0] {
        S_HUNT  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Change detection and history
    // ------------------------------------------------------------------
    logic [3:0]        r_prev;
    logic              r_primed;
    logic [3:0]        r_slot [DIGITS];
    logic [DIGITS-1:0] r_valid;
    logic              w_capture;

    // The first edge after reset captures unconditionally so a value that
    // happens to equal the pre-reset input is still recorded.
    assign w_capture = !r_primed || (digit_in != r_prev);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev   <= 4'h0;
            r_primed <= 1'b0;
            r_valid  <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                r_slot[i] <= 4'h0;
            end
        end else begin
            r_prev   <= digit_in;
            r_primed <= 1'b1;
            if (w_capture) begin
                r_slot[0] <= digit_in;
                for (int i = 1; i < DIGITS; i++) begin
                    r_slot[i] <= r_slot[i-1];
                end
                r_valid <= {r_valid[DIGITS-2:0], 1'b1};
            end
        end
    end

    // ------------------------------------------------------------------
    // Display scan and segment decode
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  r_div_cnt;
    logic [IDX_W-1:0]  r_scan_idx;
    logic [6:0]        w_seg_raw;
    logic [DIGITS-1:0] w_an_raw;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
        case (d)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    always_comb begin
        w_seg_raw = 7'h00;
        if (r_valid[r_scan_idx]) begin
            w_seg_raw = hex_to_seg(r_slot[r_scan_idx]);
        end
        w_an_raw = c_an_pos0 << r_scan_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt  <= '0;
            r_scan_idx <= '0;
            seg        <= c_seg_blank;
            an         <= c_an_rst;
        end else begin
            if (r_div_cnt == CNT_W'(SCAN_DIV - 1)) begin
                r_div_cnt  <= '0;
                r_scan_idx <= (r_scan_idx == IDX_W'(DIGITS - 1)) ? '0 : r_scan_idx + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            seg <= SEG_ACTIVE_LOW ? ~w_seg_raw : w_seg_raw;
            an  <= SEG_ACTIVE_LOW ? ~w_an_raw  : w_an_raw;
        end
    end

    // ------------------------------------------------------------------
    // Sequence checker: expects C,0,E,3,1,2 repeating
    // ------------------------------------------------------------------
    state_t     r_state, w_state_next;
    logic [2:0] r_exp, w_exp_next;
    logic       w_err_next, w_lock_next;

    function automatic logic [3:0] seq_digit(input logic [2:0] i);
        case (i)
            3'd0:    seq_digit = 4'hC;
            3'd1:    seq_digit = 4'h0;
            3'd2:    seq_digit = 4'hE;
            3'd3:    seq_digit = 4'h3;
            3'd4:    seq_digit = 4'h1;
            default: seq_digit = 4'h2;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_HUNT;
            r_exp     <= 3'd0;
            new_digit <= 1'b0;
            seq_err   <= 1'b0;
            seq_lock  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_exp     <= w_exp_next;
            new_digit <= w_capture;
            seq_err   <= w_err_next;
            seq_lock  <= w_lock_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_exp_next   = r_exp;
        w_err_next   = 1'b0;
        w_lock_next  = seq_lock;
        if (w_capture) begin
            case (r_state)
                S_HUNT: begin
                    if (digit_in == 4'hC) begin
                        w_state_next = S_TRACK;
                        w_exp_next   = 3'd1;
                    end
                end
                default: begin
                    if (digit_in == seq_digit(r_exp)) begin
                        w_exp_next = (r_exp == 3'd5) ? 3'd0 : r_exp + 3'd1;
                        if (r_exp == 3'd5) begin
                            w_lock_next = 1'b1;
                        end
                    end else begin
                        w_err_next  = 1'b1;
                        w_lock_next = 1'b0;
                        // A stray C is itself a valid restart point.
                        if (digit_in == 4'hC) begin
                            w_state_next = S_TRACK;
                            w_exp_next   = 3'd1;
                        end else begin
                            w_state_next = S_HUNT;
                            w_exp_next   = 3'd0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_scroll_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_scroll_display
//  Description : Self-checking bench for hex_scroll_display with a
//                behavioural reference model and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_scroll_display;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam bit SEG_AL   = 1'b1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        digit_in = 4'hC;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;
    logic              new_digit, seq_err, seq_lock;

    hex_scroll_display #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(SEG_AL)
    ) dut (
        .clk(clk), .reset(reset), .digit_in(digit_in), .seg(seg), .an(an),
        .new_digit(new_digit), .seq_err(seq_err), .seq_lock(seq_lock)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0] seq_tab [6] = '{4'hC, 4'h0, 4'hE, 4'h3, 4'h1, 4'h2};

    logic [3:0]        hist[$];
    int                m_n;
    bit                m_primed;
    logic [3:0]        m_prev;
    int                m_pos;      // index in seq_tab of last matched digit, -1 = hunting
    bit                m_lock, m_new, m_err;
    logic [6:0]        m_seg;
    logic [DIGITS-1:0] m_an;
    bit                model_ok = 1'b0;

    function automatic logic [6:0] pol7(input logic [6:0] x);
        return SEG_AL ? ~x : x;
    endfunction
    function automatic logic [DIGITS-1:0] pol_an(input logic [DIGITS-1:0] x);
        return SEG_AL ? ~x : x;
    endfunction

    always @(posedge clk) begin
        int  idx;
        bit  cap;
        logic [DIGITS-1:0] one;
        if (reset) begin
            hist.delete();
            m_n = 0; m_primed = 0; m_pos = -1;
            m_lock = 0; m_new = 0; m_err = 0;
            m_seg = pol7(7'h00);
            m_an  = pol_an(DIGITS'(1));
            model_ok = 1'b1;
        end else begin
            idx = (m_n / SCAN_DIV) % DIGITS;
            one = DIGITS'(1) << idx;
            m_an  = pol_an(one);
            m_seg = pol7(idx < hist.size() ? dec_tab[hist[idx]] : 7'h00);
            cap = !m_primed || (digit_in != m_prev);
            m_n++;
            m_new = cap;
            m_err = 0;
            if (cap) begin
                hist.push_front(digit_in);
                if (hist.size() > DIGITS) void'(hist.pop_back());
                if (m_pos < 0) begin
                    if (digit_in == 4'hC) m_pos = 0;
                end else if (digit_in == seq_tab[(m_pos + 1) % 6]) begin
                    m_pos = (m_pos + 1) % 6;
                    if (m_pos == 5) m_lock = 1;
                end else begin
                    m_err = 1; m_lock = 0;
                    m_pos = (digit_in == 4'hC) ? 0 : -1;
                end
            end
        end
        m_primed = !reset;
        m_prev = digit_in;
    end

    int new_cnt = 0;
    int err_cnt = 0;

    always @(negedge clk) begin
        if (model_ok) begin
            chk("seg", 32'(seg), 32'(m_seg));
            chk("an", 32'(an), 32'(m_an));
            chk("new_digit", 32'(new_digit), 32'(m_new));
            chk("seq_err", 32'(seq_err), 32'(m_err));
            chk("seq_lock", 32'(seq_lock), 32'(m_lock));
            if (new_digit) new_cnt++;
            if (seq_err) err_cnt++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive(input logic [3:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            digit_in = d;
            @(posedge clk);
            #1;
        end
    endtask

    logic [6:0] seg_at [DIGITS];

    task automatic scan_record(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            for (int p = 0; p < DIGITS; p++) begin
                if (an == pol_an(DIGITS'(1) << p)) seg_at[p] = seg;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] seg0;
        int         an0_cnt;

        // Reset hold, then release with C
        reset = 1'b1; digit_in = 4'hC;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_an", 32'(an), 32'h0000000E);
        chk("rst_seg", 32'(seg), 32'h0000007F);
        reset = 1'b0;
        new_cnt = 0; err_cnt = 0;
        drive(4'hC, 1);
        chk("first_cap", 32'(new_digit), 32'd1);
        seg0 = 7'h00;
        for (int i = 0; i < 10; i++) begin
            drive(4'hC, 1);
            if (an == 4'b1110) seg0 = seg;
        end
        chk("slot0_C", 32'(seg0), 32'h00000046);

        // History scroll
        drive(4'h0, 11);
        drive(4'hE, 11);
        drive(4'h3, 11);
        chk("cap_count", 32'(new_cnt), 32'd4);
        scan_record(16);
        chk("scan_p3", 32'(seg_at[3]), 32'h00000046);
        chk("scan_p2", 32'(seg_at[2]), 32'h00000040);
        chk("scan_p1", 32'(seg_at[1]), 32'h00000006);
        chk("scan_p0", 32'(seg_at[0]), 32'h00000030);

        // Two clean periods from a fresh start
        reset = 1'b1;
        drive(4'h3, 1);
        reset = 1'b0;
        err_cnt = 0;
        for (int k = 0; k < 5; k++) drive(seq_tab[k], 11);
        chk("lock_before_2", 32'(seq_lock), 32'd0);
        drive(4'h2, 1);
        chk("lock_at_2", 32'(seq_lock), 32'd1);
        drive(4'h2, 10);
        for (int k = 0; k < 6; k++) drive(seq_tab[k], 11);
        chk("lock_held", 32'(seq_lock), 32'd1);
        chk("no_err", 32'(err_cnt), 32'd0);

        // Out-of-order digit while locked
        drive(4'hC, 11);
        drive(4'h0, 11);
        drive(4'h5, 1);
        chk("err_pulse", 32'(seq_err), 32'd1);
        chk("lock_drop", 32'(seq_lock), 32'd0);
        drive(4'h5, 10);
        chk("err_count", 32'(err_cnt), 32'd1);
        for (int k = 0; k < 5; k++) drive(seq_tab[k], 11);
        chk("relock_pending", 32'(seq_lock), 32'd0);
        drive(4'h2, 11);
        chk("relock", 32'(seq_lock), 32'd1);

        // Long constant input
        new_cnt = 0;
        an0_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            drive(4'h2, 1);
            if (i >= 4 && an == 4'b1110) an0_cnt++;
        end
        chk("hold_no_cap", 32'(new_cnt), 32'd0);
        chk("an0_dwell", 32'(an0_cnt), 32'd24);

        // One-cycle reset mid-period, same value afterwards
        reset = 1'b1;
        drive(4'h2, 1);
        chk("mid_rst_an", 32'(an), 32'h0000000E);
        chk("mid_rst_seg", 32'(seg), 32'h0000007F);
        chk("mid_rst_lock", 32'(seq_lock), 32'd0);
        reset = 1'b0;
        drive(4'h2, 1);
        chk("post_rst_cap", 32'(new_digit), 32'd1);
        chk("post_rst_lock", 32'(seq_lock), 32'd0);
        drive(4'h2, 4);
        scan_record(16);
        chk("post_rst_p0", 32'(seg_at[0]), 32'h00000024);
        chk("post_rst_p1", 32'(seg_at[1]), 32'h0000007F);
        chk("post_rst_p3", 32'(seg_at[3]), 32'h0000007F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
